pix_fifo_arbiter: RTL

PIX_FIFO_ARBITER -- requirements
Module: pix_fifo_arbiter

---
 rtl/pix_fifo_arbiter_pkg.sv | 31 +++
 rtl/pix_fifo_arbiter_fill.sv | 74 +++++++
 rtl/pix_fifo_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/pix_fifo_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// pix_fifo_arbiter_pkg
// Shared definitions for the pixel FIFO write-port arbiter:
//   - default geometry constants (FIFO depth, pixel width, burst length)
//   - arbiter state encoding (arb_state_t)
//   - producer identifier used by the last-served pointer (src_t)
//   - fill_width(): bit width needed to hold a count of 0..depth inclusive
// -----------------------------------------------------------------------------
package pix_fifo_arbiter_pkg;

  localparam int DEF_MEM_LENGTH = 8;
  localparam int DEF_PIX_WIDTH  = 16;
  localparam int DEF_BURST      = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_A = 2'd1,
    SERVE_B = 2'd2
  } arb_state_t;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_t;

  // A counter that must represent both 0 and 'depth' needs clog2(depth+1) bits.
  function automatic int fill_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pix_fifo_arbiter_fill.sv
// -----------------------------------------------------------------------------
// fill_tracker
// Saturating up/down occupancy counter for the downstream pixel FIFO.
// The count moves at acceptance time (not when the write strobe fires), so a
// beat that is still in the load pipeline already owns its slot.
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   synchronous, active-low reset
//   inc_i    in   one beat accepted this cycle
//   dec_i    in   FIFO read completed this cycle (one word removed)
//   fill_o   out  words held or committed
//   full_o   out  fill_o == MEM_LENGTH
//   empty_o  out  fill_o == 0
//   err_o    out  sticky: a read was acknowledged while nothing was held
// -----------------------------------------------------------------------------
module fill_tracker
  import pix_fifo_arbiter_pkg::*;
#(
  parameter int MEM_LENGTH = DEF_MEM_LENGTH,
  parameter int FILL_W     = fill_width(MEM_LENGTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc_i,
  input  logic              dec_i,
  output logic [FILL_W-1:0] fill_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              err_o
);

  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(MEM_LENGTH);
  localparam logic [FILL_W-1:0] FILL_ONE = FILL_W'(1);

  logic [FILL_W-1:0] fill_q, fill_d;
  logic              err_q,  err_d;

  // NOTE: every always_comb output gets a default before any branch; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    fill_d = fill_q;
    err_d  = err_q;
    unique case ({inc_i, dec_i})
      // The arbiter never accepts while full; the guard keeps the counter
      // bounded regardless.
      2'b10: if (fill_q != FILL_MAX) fill_d = fill_q + FILL_ONE;
      2'b01: begin
        if (fill_q == '0) err_d  = 1'b1;
        else              fill_d = fill_q - FILL_ONE;
      end
      // Accept and read in the same cycle cancel out, including at zero.
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, and the reset
  // is sampled on the clock edge (synchronous), not in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fill_q <= '0;
      err_q  <= 1'b0;
    end else begin
      fill_q <= fill_d;
      err_q  <= err_d;
    end
  end

  assign fill_o  = fill_q;
  assign full_o  = (fill_q == FILL_MAX);
  assign empty_o = (fill_q == '0);
  assign err_o   = err_q;

endmodule

// File: rtl/pix_fifo_arbiter.sv
// -----------------------------------------------------------------------------
// pix_fifo_arbiter
// Arbitrates two pixel producers onto a single FIFO write port. A producer is
// granted for up to BURST accepted beats, then the grant is re-arbitrated with
// the other producer preferred. Accepted pixels are presented to the FIFO one
// cycle later as a registered write strobe plus data. Occupancy is tracked
// locally from accepts and read acknowledges; the block holds no pixel storage.
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-low reset
//   req_a/b   in   producer A/B holds a pixel
//   pix_a/b   in   producer A/B pixel data
//   grant_a/b out  producer A/B owns the write port (decoded from state)
//   load      out  FIFO write strobe (registered)
//   pix_in    out  FIFO write data (registered, holds when idle)
//   fifo_ack  in   FIFO read completed, one word removed
//   fill      out  words held or committed in the FIFO
//   full      out  fill == MEM_LENGTH
//   empty     out  fill == 0
//   err       out  sticky: fifo_ack seen while empty
// -----------------------------------------------------------------------------
module pix_fifo_arbiter
  import pix_fifo_arbiter_pkg::*;
#(
  parameter int MEM_LENGTH = DEF_MEM_LENGTH,
  parameter int PIX_WIDTH  = DEF_PIX_WIDTH,
  parameter int BURST      = DEF_BURST
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                req_a,
  input  logic                                req_b,
  input  logic [PIX_WIDTH-1:0]                pix_a,
  input  logic [PIX_WIDTH-1:0]                pix_b,
  output logic                                grant_a,
  output logic                                grant_b,
  output logic                                load,
  output logic [PIX_WIDTH-1:0]                pix_in,
  input  logic                                fifo_ack,
  output logic [fill_width(MEM_LENGTH)-1:0]   fill,
  output logic                                full,
  output logic                                empty,
  output logic                                err
);

  localparam int               CNT_W     = $clog2(BURST + 1);
  localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BURST);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  arb_state_t           state_q,    state_d;
  src_t                 last_q,     last_d;
  logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic                 load_q,     load_d;
  logic [PIX_WIDTH-1:0] pix_in_q,   pix_in_d;

  logic                 accept;
  logic                 req_own;
  logic                 req_other;
  logic                 burst_done;
  arb_state_t           other_state;
  logic [CNT_W-1:0]     beat_next;

  // ---------------------------------------------------------------------------
  // Grant decode and beat acceptance
  // ---------------------------------------------------------------------------
  assign grant_a = (state_q == SERVE_A);
  assign grant_b = (state_q == SERVE_B);

  // While full the grant stays up but nothing is taken.
  assign accept = ((grant_a & req_a) | (grant_b & req_b)) & ~full;

  // Requests seen from the current owner's point of view; only meaningful in
  // the SERVE states.
  assign req_own     = grant_a ? req_a : req_b;
  assign req_other   = grant_a ? req_b : req_a;
  assign other_state = grant_a ? SERVE_B : SERVE_A;
  assign beat_next   = beat_cnt_q + CNT_ONE;
  assign burst_done  = accept & (beat_next == BURST_CNT);

  // ---------------------------------------------------------------------------
  // Arbitration FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    last_d     = last_q;

    unique case (state_q)
      IDLE: begin
        if (req_a && req_b) begin
          // Tie goes to whichever producer was not served most recently.
          state_d = (last_q == SRC_B) ? SERVE_A : SERVE_B;
        end else if (req_a) begin
          state_d = SERVE_A;
        end else if (req_b) begin
          state_d = SERVE_B;
        end
      end

      SERVE_A, SERVE_B: begin
        if (!req_own || burst_done) begin
          // Hand over if the other side is waiting; otherwise re-grant the
          // same producer with a fresh burst, or fall back to IDLE.
          if (req_other)    state_d = other_state;
          else if (req_own) state_d = state_q;
          else              state_d = IDLE;
          beat_cnt_d = '0;
        end else if (accept) begin
          beat_cnt_d = beat_next;
        end
        // When full with the request held, nothing above fires: state and
        // beat count both freeze.
      end

      default: begin
        state_d    = IDLE;
        beat_cnt_d = '0;
      end
    endcase

    if (state_d == SERVE_A)      last_d = SRC_A;
    else if (state_d == SERVE_B) last_d = SRC_B;
  end

  // ---------------------------------------------------------------------------
  // Write-port pipeline: accepted pixel is presented one cycle later.
  // ---------------------------------------------------------------------------
  always_comb begin
    load_d   = accept;
    pix_in_d = pix_in_q;
    if (accept) pix_in_d = grant_a ? pix_a : pix_b;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      last_q     <= SRC_B;  // so A wins the first tie
      beat_cnt_q <= '0;
      load_q     <= 1'b0;   // drops any beat still waiting to be written
      pix_in_q   <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      beat_cnt_q <= beat_cnt_d;
      load_q     <= load_d;
      pix_in_q   <= pix_in_d;
    end
  end

  assign load   = load_q;
  assign pix_in = pix_in_q;

  // ---------------------------------------------------------------------------
  // FIFO occupancy
  // ---------------------------------------------------------------------------
  fill_tracker #(
    .MEM_LENGTH (MEM_LENGTH)
  ) u_fill (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (accept),
    .dec_i   (fifo_ack),
    .fill_o  (fill),
    .full_o  (full),
    .empty_o (empty),
    .err_o   (err)
  );

endmodule
